aes_128_sub_bytes: RTL and testbench

- Requester side of the 256x8 dual-port S-box BRAM: runs SubBytes on a 128-bit AES state through both S-box read ports, two bytes per cycle.
- Sits between the round controller and the S-box BRAM. Drives addra/addrb/ena/enb/wea/web and consumes doa/dob.
- One transaction is 16 S-box lookups, with a start/done handshake to the round controller.

---
 rtl/aes_pkg.sv | 30 +++
 rtl/aes_sbox_cap_pipe.sv | 56 +++++
 rtl/aes_128_sub_bytes.sv | 157 +++++++++++++++
 tb/tb_aes_128_sub_bytes.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES SubBytes requester.
// Contents:
//   AES_NBYTES / AES_BYTE_W / AES_STATE_W : state geometry (16 bytes of 8 bits)
//   SBOX_DEPTH / SBOX_ADDR_W              : S-box table depth and address width
//   aes_state_e                           : requester FSM states
//   aes_get_byte()                        : MSB-first byte select (byte 0 = bits 127:120)
package aes_pkg;

  localparam int AES_NBYTES  = 16;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_STATE_W = AES_NBYTES * AES_BYTE_W;
  localparam int SBOX_DEPTH  = 256;
  localparam int SBOX_ADDR_W = $clog2(SBOX_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } aes_state_e;

  // Byte idx of an AES state, counting from the most significant byte.
  function automatic logic [AES_BYTE_W-1:0] aes_get_byte(
    input logic [AES_STATE_W-1:0] state,
    input logic [3:0]             idx
  );
    return state[(AES_STATE_W - 1) - AES_BYTE_W * int'(idx) -: AES_BYTE_W];
  endfunction

endpackage

// File: rtl/aes_sbox_cap_pipe.sv
// Delay line that carries the "pair issued" flag and its pair index alongside
// the S-box read latency, so the capture logic knows which bytes the returning
// read data belong to.
// Ports:
//   clk     : clock
//   srst    : synchronous active-high reset, clears every stage
//   i_valid : a pair was issued to the S-box this cycle
//   i_idx   : pair index of that issue
//   o_valid : delayed by SBOX_LAT cycles, aligned with S-box read data
//   o_idx   : delayed pair index
module aes_sbox_cap_pipe
  import aes_pkg::*;
#(
  parameter int SBOX_LAT = 1,
  parameter int IDX_W    = 3
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             i_valid,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  genvar gi;
  generate
    for (gi = 0; gi < SBOX_LAT; gi++) begin : g_stage
      logic             r_valid;
      logic [IDX_W-1:0] r_idx;
      logic             w_valid_in;
      logic [IDX_W-1:0] w_idx_in;

      if (gi == 0) begin : g_head
        assign w_valid_in = i_valid;
        assign w_idx_in   = i_idx;
      end else begin : g_tail
        assign w_valid_in = g_stage[gi-1].r_valid;
        assign w_idx_in   = g_stage[gi-1].r_idx;
      end

      always_ff @(posedge clk) begin
        if (srst) begin
          r_valid <= 1'b0;
          r_idx   <= '0;
        end else begin
          r_valid <= w_valid_in;
          r_idx   <= w_idx_in;
        end
      end
    end
  endgenerate

  assign o_valid = g_stage[SBOX_LAT-1].r_valid;
  assign o_idx   = g_stage[SBOX_LAT-1].r_idx;

endmodule

// File: rtl/aes_128_sub_bytes.sv
// SubBytes requester: pushes the 16 bytes of an AES state through both read
// ports of a dual-port S-box RAM, two bytes per cycle, and returns the
// substituted state with a start/done handshake.
// Ports:
//   clk                : single clock, shared with the S-box RAM
//   kill               : synchronous active-high reset / abort
//   start, state_in    : request (sampled only in IDLE) and input state
//   busy, done         : status; done pulses one cycle with state_out valid
//   state_out          : substituted state, held until the next done or kill
//   sb_ena/enb         : S-box read enables (high only while issuing)
//   sb_wea/web         : S-box write enables, always 0
//   sb_addra/addrb     : S-box addresses (even / odd byte of the pair)
//   sb_doa/dob         : S-box read data, SBOX_LAT cycles after the address
module aes_128_sub_bytes
  import aes_pkg::*;
#(
  parameter int SBOX_LAT = 1,
  parameter int NBYTES   = AES_NBYTES
) (
  input  logic                   clk,
  input  logic                   kill,
  input  logic                   start,
  input  logic [AES_STATE_W-1:0] state_in,
  output logic                   busy,
  output logic                   done,
  output logic [AES_STATE_W-1:0] state_out,
  output logic                   sb_ena,
  output logic                   sb_enb,
  output logic                   sb_wea,
  output logic                   sb_web,
  output logic [SBOX_ADDR_W-1:0] sb_addra,
  output logic [SBOX_ADDR_W-1:0] sb_addrb,
  input  logic [AES_BYTE_W-1:0]  sb_doa,
  input  logic [AES_BYTE_W-1:0]  sb_dob
);

  localparam int NPAIRS = NBYTES / 2;
  localparam int K_W    = $clog2(NPAIRS);
  localparam int PAIR_W = 2 * AES_BYTE_W;

  aes_state_e             r_state;
  logic [K_W-1:0]         r_k;
  logic [1:0]             r_drain_cnt;
  logic [AES_STATE_W-1:0] r_state_in;
  logic [AES_STATE_W-1:0] r_result;
  logic [AES_STATE_W-1:0] r_state_out;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_ena;
  logic [SBOX_ADDR_W-1:0] r_addra;
  logic [SBOX_ADDR_W-1:0] r_addrb;

  logic                   w_cap_valid;
  logic [K_W-1:0]         w_cap_idx;
  logic [K_W-1:0]         w_k_inc;
  logic [AES_STATE_W-1:0] w_result_next;

  assign w_k_inc = r_k + 1'b1;

  // r_ena doubles as the issue-valid bit: it is high exactly in ISSUE cycles.
  aes_sbox_cap_pipe #(
    .SBOX_LAT (SBOX_LAT),
    .IDX_W    (K_W)
  ) u_cap_pipe (
    .clk     (clk),
    .srst    (kill),
    .i_valid (r_ena),
    .i_idx   (r_k),
    .o_valid (w_cap_valid),
    .o_idx   (w_cap_idx)
  );

  // Result with this cycle's returning pair merged in. state_out loads from
  // this view so the last pair, arriving on the edge that enters DONE, is seen.
  genvar gi;
  generate
    for (gi = 0; gi < NPAIRS; gi++) begin : g_merge
      assign w_result_next[AES_STATE_W-1-PAIR_W*gi -: PAIR_W] =
        (w_cap_valid && (w_cap_idx == K_W'(gi))) ? {sb_doa, sb_dob}
                                                 : r_result[AES_STATE_W-1-PAIR_W*gi -: PAIR_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (kill) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_drain_cnt <= '0;
      r_state_in  <= '0;
      r_result    <= '0;
      r_state_out <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ena       <= 1'b0;
      r_addra     <= '0;
      r_addrb     <= '0;
    end else begin
      r_done   <= 1'b0;
      r_result <= w_result_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // First pair is addressed straight from state_in so it is on
            // the bus in the first ISSUE cycle.
            r_state_in <= state_in;
            r_k        <= '0;
            r_ena      <= 1'b1;
            r_addra    <= aes_get_byte(state_in, 4'd0);
            r_addrb    <= aes_get_byte(state_in, 4'd1);
            r_busy     <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_k <= w_k_inc;
          if (r_k == K_W'(NPAIRS - 1)) begin
            r_ena       <= 1'b0;
            r_addra     <= '0;
            r_addrb     <= '0;
            r_drain_cnt <= '0;
            r_state     <= ST_DRAIN;
          end else begin
            r_addra <= aes_get_byte(r_state_in, {w_k_inc, 1'b0});
            r_addrb <= aes_get_byte(r_state_in, {w_k_inc, 1'b1});
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == 2'(SBOX_LAT - 1)) begin
            r_state_out <= w_result_next;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign state_out = r_state_out;
  assign sb_ena    = r_ena;
  assign sb_enb    = r_ena;
  assign sb_wea    = 1'b0;
  assign sb_web    = 1'b0;
  assign sb_addra  = r_addra;
  assign sb_addrb  = r_addrb;

endmodule

// File: tb/tb_aes_128_sub_bytes.sv
// Bench for aes_128_sub_bytes: one DUT per legal S-box latency (1 and 2),
// each wired to its own dual-port S-box RAM model whose contents are derived
// from GF(2^8) inversion plus the AES affine map.
module tb_aes_128_sub_bytes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         kill_v      [2];
  logic         start_v     [2];
  logic [127:0] state_in_v  [2];
  logic         busy_v      [2];
  logic         done_v      [2];
  logic [127:0] state_out_v [2];
  logic         ena_v       [2];
  logic         enb_v       [2];
  logic         wea_v       [2];
  logic         web_v       [2];
  logic [7:0]   addra_v     [2];
  logic [7:0]   addrb_v     [2];
  logic [7:0]   doa_v       [2];
  logic [7:0]   dob_v       [2];

  logic [7:0]   sbox_tab [256];

  int n_vec  = 0;
  int n_fail = 0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      logic [7:0] r_a1, r_b1, r_a2, r_b2;

      aes_128_sub_bytes #(.SBOX_LAT(gi + 1), .NBYTES(16)) u_dut (
        .clk       (clk),
        .kill      (kill_v[gi]),
        .start     (start_v[gi]),
        .state_in  (state_in_v[gi]),
        .busy      (busy_v[gi]),
        .done      (done_v[gi]),
        .state_out (state_out_v[gi]),
        .sb_ena    (ena_v[gi]),
        .sb_enb    (enb_v[gi]),
        .sb_wea    (wea_v[gi]),
        .sb_web    (web_v[gi]),
        .sb_addra  (addra_v[gi]),
        .sb_addrb  (addrb_v[gi]),
        .sb_doa    (doa_v[gi]),
        .sb_dob    (dob_v[gi])
      );

      // S-box RAM: first register is the array read, second is the optional
      // output register used for the two-cycle configuration.
      always @(posedge clk) begin
        if (kill_v[gi]) begin
          r_a1 <= 8'h00; r_b1 <= 8'h00; r_a2 <= 8'h00; r_b2 <= 8'h00;
        end else begin
          if (ena_v[gi]) r_a1 <= sbox_tab[addra_v[gi]];
          if (enb_v[gi]) r_b1 <= sbox_tab[addrb_v[gi]];
          r_a2 <= r_a1;
          r_b2 <= r_b1;
        end
      end
      assign doa_v[gi] = (gi == 0) ? r_a1 : r_a2;
      assign dob_v[gi] = (gi == 0) ? r_b1 : r_b2;
    end
  endgenerate

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int c = 1; c < 256; c++)
      if (gf_mul(a, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = sbox_calc(s[127 - 8*i -: 8]);
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int d, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (lat=%0d): got %h required %h", name, d + 1, act, exp);
    end
  endtask

  // One transaction on DUT d. With hammer set, start stays high with fresh
  // random state_in on every busy cycle; the result must still match din.
  task automatic run_txn(input int d, input logic [127:0] din, input logic [127:0] exp, input bit hammer);
    int lat;
    int busy_cnt;
    int done_at;
    lat = d + 1;
    busy_cnt = 0;
    done_at = 0;
    @(negedge clk);
    start_v[d] = 1'b1;
    state_in_v[d] = din;
    @(posedge clk);
    #1;
    start_v[d] = hammer;
    if (hammer) state_in_v[d] = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 1; c <= 24 && done_at == 0; c++) begin
      @(negedge clk);
      chk("write_en", d, {126'd0, wea_v[d], web_v[d]}, 128'd0);
      chk("read_en", d, {126'd0, ena_v[d], enb_v[d]}, (c <= 8) ? 128'd3 : 128'd0);
      if (c <= 8) chk("addr_pair", d, {112'd0, addra_v[d], addrb_v[d]}, {112'd0, din[127 - 16*(c-1) -: 16]});
      if (busy_v[d]) busy_cnt++;
      if (done_v[d]) begin
        done_at = c;
        chk("state_out", d, state_out_v[d], exp);
      end else if (hammer) begin
        state_in_v[d] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    start_v[d] = 1'b0;
    chk("done_latency", d, 128'(done_at), 128'(9 + lat));
    chk("busy_cycles", d, 128'(busy_cnt), 128'(8 + lat));
    $display("txn lat=%0d in=%h out=%h done_at=%0d", lat, din, state_out_v[d], done_at);
  endtask

  task automatic watch_idle(input int d, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("idle_quiet", d, {125'd0, busy_v[d], done_v[d], ena_v[d]}, 128'd0);
    end
  endtask

  task automatic chk_zero(input string name, input int d);
    chk({name, "_state_out"}, d, state_out_v[d], 128'd0);
    chk({name, "_ctl"}, d, {108'd0, busy_v[d], done_v[d], ena_v[d], enb_v[d], addra_v[d], addrb_v[d]}, 128'd0);
  endtask

  // Abort during the fourth issue cycle.
  task automatic kill_test(input int d);
    @(negedge clk);
    start_v[d] = 1'b1;
    state_in_v[d] = 128'h0123456789abcdeffedcba9876543210;
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    for (int c = 1; c <= 4; c++) @(negedge clk);
    kill_v[d] = 1'b1;
    @(posedge clk);
    #1;
    kill_v[d] = 1'b0;
    @(negedge clk);
    chk_zero("after_kill", d);
    $display("kill lat=%0d busy=%0b done=%0b out=%h", d + 1, busy_v[d], done_v[d], state_out_v[d]);
    watch_idle(d, 14);
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816};
    vecs[1] = '{128'h00000000000000000000000000000000, 128'h63636363636363636363636363636363};
    vecs[2] = '{128'hffffffffffffffffffffffffffffffff, 128'h16161616161616161616161616161616};
    vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76};

    for (int d = 0; d < 2; d++) begin
      kill_v[d] = 1'b1;
      start_v[d] = 1'b0;
      state_in_v[d] = '0;
    end
    for (int a = 0; a < 256; a++) sbox_tab[a] = sbox_calc(8'(a));

    repeat (3) @(posedge clk);
    #1;
    kill_v[0] = 1'b0;
    kill_v[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk_zero("reset", d);

    for (int d = 0; d < 2; d++) begin
      // Table vectors back to back: each start lands in the cycle after done.
      for (int i = 0; i < 4; i++) run_txn(d, vecs[i].din, vecs[i].exp, 1'b0);
      run_txn(d, vecs[0].din, vecs[0].exp, 1'b1);
      watch_idle(d, 12);
      kill_test(d);
      run_txn(d, vecs[3].din, vecs[3].exp, 1'b0);
      for (int r = 0; r < 10; r++) begin
        logic [127:0] rin;
        rin = {$urandom, $urandom, $urandom, $urandom};
        run_txn(d, rin, ref_sub(rin), 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
